// File: rtl/spi_master_mc.sv
// rtl/spi_master_mc.sv - multi chip-select SPI master with TX/RX byte FIFOs on the iomem bus
module spi_master_mc #(
  parameter int NUM_CS      = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [1:0] ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_SHIFT = 2'd2, ST_DONE = 2'd3;
  localparam logic [1:0] R_CTRL = 2'd0, R_CS = 2'd1, R_DATA = 2'd2, R_STAT = 2'd3;

  logic              ready_q;
  logic [31:0]       rdata_q;
  logic [19:0]       ctrl_q;
  logic [NUM_CS-1:0] cs_q;
  logic              rx_ovf_q, tx_ovf_q;
  logic [7:0]        tx_mem [FIFO_DEPTH];
  logic [7:0]        rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [CW-1:0]     tx_cnt_q, rx_cnt_q;
  logic [1:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d, div_q, div_d;
  logic [3:0]        edge_q, edge_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [7:0]        tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;

  logic        access, wr, rd, tx_full, tx_empty, rx_full, rx_empty, busy;
  logic        tx_push, tx_pop, rx_push, rx_pop, rx_ovf_set, stat_wr;
  logic [1:0]  sel;
  logic [7:0]  tx_load, rx_byte;
  logic [31:0] rd_word, stat_word;
  logic        unused_bits;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
  endfunction

  // A new access is only accepted while no acknowledge is outstanding
  assign access     = iomem_valid && !ready_q;
  assign wr         = access && (iomem_wstrb != 4'b0);
  assign rd         = access && (iomem_wstrb == 4'b0);
  assign sel        = iomem_addr[3:2];
  assign tx_full    = (tx_cnt_q == DEPTH_C);
  assign tx_empty   = (tx_cnt_q == '0);
  assign rx_full    = (rx_cnt_q == DEPTH_C);
  assign rx_empty   = (rx_cnt_q == '0);
  assign busy       = (state_q != ST_IDLE) || !tx_empty;
  assign tx_push    = wr && (sel == R_DATA) && !tx_full;
  assign tx_pop     = (state_q == ST_LOAD);
  assign rx_push    = (state_q == ST_DONE) && !rx_full;
  assign rx_ovf_set = (state_q == ST_DONE) && rx_full;
  assign rx_pop     = rd && (sel == R_DATA) && !rx_empty;
  assign stat_wr    = wr && (sel == R_STAT);
  assign tx_load    = ctrl_q[18] ? rev8(tx_mem[tx_rptr_q]) : tx_mem[tx_rptr_q];
  assign rx_byte    = lsb_q ? rev8(rx_sh_q) : rx_sh_q;
  assign stat_word  = {8'b0, 8'(rx_cnt_q), 8'(tx_cnt_q), 3'b0, tx_ovf_q, rx_ovf_q, rx_empty, tx_full, busy};
  assign unused_bits = ^{iomem_addr[31:4], iomem_addr[1:0], iomem_wdata[31:20]};

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;
  assign spi_cs_n    = ~cs_q;
  assign irq         = ctrl_q[19] && !rx_empty;

  // Read-data mux; an empty RX FIFO reads as zero
  always_comb begin
    rd_word = '0;
    case (sel)
      R_CTRL:  rd_word = {12'b0, ctrl_q};
      R_CS:    rd_word = {{(32-NUM_CS){1'b0}}, cs_q};
      R_DATA:  rd_word = rx_empty ? 32'b0 : {24'b0, rx_mem[rx_rptr_q]};
      default: rd_word = stat_word;
    endcase
  end

  // Bus handshake, control registers and sticky overflow flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      ctrl_q   <= {4'b0, 16'(DEFAULT_DIV)};
      cs_q     <= '0;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      ready_q <= access;
      rdata_q <= rd ? rd_word : 32'b0;
      if (wr && sel == R_CTRL) ctrl_q <= iomem_wdata[19:0];
      if (wr && sel == R_CS)   cs_q   <= iomem_wdata[NUM_CS-1:0];
      rx_ovf_q <= (rx_ovf_q && !(stat_wr && iomem_wdata[3])) || rx_ovf_set;
      tx_ovf_q <= (tx_ovf_q && !(stat_wr && iomem_wdata[4])) || (wr && sel == R_DATA && tx_full);
    end
  end

  // FIFO storage; contents need no reset since counts gate every read
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= iomem_wdata[7:0];
    if (rx_push) rx_mem[rx_wptr_q] <= rx_byte;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q <= '0; tx_rptr_q <= '0; tx_cnt_q <= '0;
      rx_wptr_q <= '0; rx_rptr_q <= '0; rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_ONE;
      if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_ONE;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_ONE;
      if (tx_push && !tx_pop) tx_cnt_q <= tx_cnt_q + CNT_ONE;
      if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CNT_ONE;
      if (rx_push && !rx_pop) rx_cnt_q <= rx_cnt_q + CNT_ONE;
      if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CNT_ONE;
    end
  end

  // Shift engine: mode and divider are latched at LOAD so CTRL writes apply from the next byte
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; edge_d = edge_q; sclk_d = sclk_q; mosi_d = mosi_q;
    tx_sh_d = tx_sh_q; rx_sh_d = rx_sh_q; cpha_d = cpha_q; lsb_d = lsb_q; div_d = div_q;
    case (state_q)
      ST_IDLE: begin
        sclk_d = ctrl_q[17];
        mosi_d = 1'b1;
        if (!tx_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tx_sh_d = tx_load;
        cpha_d  = ctrl_q[16];
        lsb_d   = ctrl_q[18];
        div_d   = ctrl_q[15:0];
        cnt_d   = ctrl_q[15:0];
        edge_d  = 4'd0;
        sclk_d  = ctrl_q[17];
        if (!ctrl_q[16]) mosi_d = tx_load[7];
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == 16'd0) begin
          cnt_d  = div_q;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 4'd1;
          // Even edges are leading; sampling happens on the leading edge only when CPHA=0
          if (edge_q[0] == cpha_q) begin
            rx_sh_d = {rx_sh_q[6:0], spi_miso};
          end else if (cpha_q || edge_q != 4'd15) begin
            mosi_d  = cpha_q ? tx_sh_q[7] : tx_sh_q[6];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
          if (edge_q == 4'd15) state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        mosi_d  = 1'b1;
        state_d = tx_empty ? ST_IDLE : ST_LOAD;
      end
    endcase
  end

  // Shift engine registers; reset returns SCLK/MOSI to idle immediately and drops any partial byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE; cnt_q <= '0; edge_q <= '0; sclk_q <= 1'b0; mosi_q <= 1'b1;
      tx_sh_q <= '0; rx_sh_q <= '0; cpha_q <= 1'b0; lsb_q <= 1'b0; div_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; edge_q <= edge_d; sclk_q <= sclk_d; mosi_q <= mosi_d;
      tx_sh_q <= tx_sh_d; rx_sh_q <= rx_sh_d; cpha_q <= cpha_d; lsb_q <= lsb_d; div_q <= div_d;
    end
  end
endmodule

// File: tb/tb_spi_master_mc.sv
// tb/tb_spi_master_mc.sv - scoreboard bench for spi_master_mc
module tb_spi_master_mc;
  localparam logic [1:0] A_CTRL = 2'd0, A_CS = 2'd1, A_DATA = 2'd2, A_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'b0;
  logic [31:0] iomem_addr = 32'b0;
  logic [31:0] iomem_wdata = 32'b0;
  logic [31:0] iomem_rdata;
  logic        spi_sclk, spi_mosi, spi_miso, irq;
  logic [1:0]  spi_cs_n;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] exp_q[$];
  string       nm_q[$];
  logic [31:0] last_rd = 32'b0;

  logic       loop_en = 1'b1, sl_en = 1'b0, sl_miso = 1'b1, tb_cpol = 1'b0, tb_cpha = 1'b0;
  logic [7:0] sl_sh = 8'h00;
  logic       cap_en = 1'b0;
  logic [7:0] cap_bits = 8'h00;
  int         rises = 0;
  logic       gap_en = 1'b0, gap_seen = 1'b0, prev_sclk = 1'b0;
  int         gap_cnt = 0, max_gap = 0;

  assign spi_miso = loop_en ? spi_mosi : sl_miso;

  spi_master_mc #(.NUM_CS(2), .FIFO_DEPTH(8), .DEFAULT_DIV(7)) dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: every acknowledge consumes one scoreboard entry
  always @(negedge clk) begin
    logic [32:0] e;
    string n;
    if (iomem_ready) begin
      last_rd = iomem_rdata;
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_ready: rdata %h with no access pending", iomem_rdata);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (e[32]) begin
          vectors++;
          if (iomem_rdata !== e[31:0]) begin
            miscompares++;
            $display("FAIL %s: rdata %h expected %h", n, iomem_rdata, e[31:0]);
          end
        end
      end
    end
  end

  // Slave model shifting out sl_sh MSB first in the configured mode
  always @(spi_sclk) begin
    if (sl_en && ((spi_sclk != tb_cpol) == tb_cpha)) begin
      if (tb_cpha) begin
        sl_miso = sl_sh[7]; sl_sh = {sl_sh[6:0], 1'b0};
      end else begin
        sl_sh = {sl_sh[6:0], 1'b0}; sl_miso = sl_sh[7];
      end
    end
  end

  // MOSI capture on SCLK rising edges
  always @(posedge spi_sclk) begin
    if (cap_en) begin
      cap_bits = {cap_bits[6:0], spi_mosi};
      rises++;
    end
  end

  // Longest interval between SCLK transitions, in clk cycles
  always @(negedge clk) begin
    if (gap_en) begin
      gap_cnt++;
      if (spi_sclk !== prev_sclk) begin
        if (gap_seen && gap_cnt > max_gap) max_gap = gap_cnt;
        gap_seen = 1'b1;
        gap_cnt = 0;
      end
      prev_sclk = spi_sclk;
    end
  end

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] wd,
                     input logic c, input logic [31:0] e, input string n);
    exp_q.push_back({c, e});
    nm_q.push_back(n);
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = {28'b0, a, 2'b0};
    iomem_wstrb = w ? 4'hF : 4'h0; iomem_wdata = wd;
    @(posedge clk); #1;
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(a, 1'b1, d, 1'b0, 32'b0, "write");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    bus(a, 1'b0, 32'b0, 1'b1, e, n);
  endtask

  task automatic wait_idle(input string n);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      bus(A_STAT, 1'b0, 32'b0, 1'b0, 32'b0, "poll");
      if (!last_rd[0]) done = 1'b1;
    end
    check({n, "_idle"}, done, 1'b1);
  endtask

  task automatic loop_byte(input string n, input logic [31:0] ctrl, input logic [7:0] tx,
                           input logic [7:0] exp_cap, input logic [7:0] exp_rx);
    wr(A_CTRL, ctrl);
    cap_bits = 8'h00; rises = 0; cap_en = 1'b1;
    wr(A_DATA, {24'b0, tx});
    wait_idle(n);
    cap_en = 1'b0;
    check({n, "_rises"}, rises, 8);
    check({n, "_mosi"}, cap_bits, exp_cap);
    rd(A_DATA, {24'b0, exp_rx}, {n, "_rx"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cw;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_ready", iomem_ready, 1'b0);
    check("rst_rdata", iomem_rdata, 32'b0);
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b1);
    check("rst_cs_n", spi_cs_n, 2'b11);
    check("rst_irq", irq, 1'b0);
    rd(A_CTRL, 32'h0000_0007, "rst_ctrl");
    rd(A_CS, 32'h0, "rst_cs");
    rd(A_STAT, 32'h0000_0004, "rst_stat");

    // Mode 0, div 1, irq enabled, MSB first
    loop_byte("mode0", 32'h0008_0001, 8'hA5, 8'hA5, 8'hA5);
    check("irq_after_read", irq, 1'b0);
    wr(A_CTRL, 32'h0008_0001);
    wr(A_DATA, 32'h0000_0033);
    wait_idle("irq");
    check("irq_rx_pending", irq, 1'b1);
    rd(A_DATA, 32'h33, "irq_rx");

    // LSB first and divider 0
    loop_byte("lsb", 32'h0004_0001, 8'hC1, 8'h83, 8'hC1);
    loop_byte("div0", 32'h0000_0000, 8'h5A, 8'h5A, 8'h5A);

    // Modes 1..3 against the slave model
    for (int m = 1; m < 4; m++) begin
      cw = 32'd2; cw[17] = m[1]; cw[16] = m[0];
      wr(A_CTRL, cw);
      repeat (3) @(posedge clk);
      #1 check($sformatf("mode%0d_idle_sclk", m), spi_sclk, cw[17]);
      tb_cpol = cw[17]; tb_cpha = cw[16];
      sl_sh = 8'h3C; sl_miso = 1'b0;
      loop_en = 1'b0; sl_en = 1'b1;
      wr(A_DATA, 32'h0000_00FF);
      wait_idle($sformatf("mode%0d", m));
      sl_en = 1'b0; loop_en = 1'b1;
      rd(A_DATA, 32'h3C, $sformatf("mode%0d_rx", m));
      check($sformatf("mode%0d_end_sclk", m), spi_sclk, cw[17]);
    end

    // Burst of 8 bytes: order preserved, at most a 2-cycle pause between bytes
    wr(A_CTRL, 32'h0000_0001);
    repeat (2) @(posedge clk);
    prev_sclk = spi_sclk; gap_seen = 1'b0; gap_cnt = 0; max_gap = 0; gap_en = 1'b1;
    for (int i = 0; i < 8; i++) wr(A_DATA, i);
    wait_idle("burst");
    gap_en = 1'b0;
    check("burst_gap", (max_gap >= 2 && max_gap <= 4), 1'b1);
    rd(A_STAT, 32'h0008_0000, "burst_stat");
    for (int i = 0; i < 8; i++) rd(A_DATA, i, $sformatf("burst_rx%0d", i));

    // Held valid on an empty RX read: two single-cycle acknowledges, both returning 0
    exp_q.push_back({1'b1, 32'h0}); nm_q.push_back("held_rd0");
    exp_q.push_back({1'b1, 32'h0}); nm_q.push_back("held_rd1");
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = 32'h8; iomem_wstrb = 4'h0;
    @(negedge clk) check("held_ready_c0", iomem_ready, 1'b0);
    @(negedge clk) check("held_ready_c1", iomem_ready, 1'b1);
    @(negedge clk) check("held_ready_c2", iomem_ready, 1'b0);
    @(negedge clk) check("held_ready_c3", iomem_ready, 1'b1);
    @(posedge clk); #1 iomem_valid = 1'b0;
    @(posedge clk); #1;
    rd(A_STAT, 32'h0000_0004, "held_stat");

    // Overflow: 9 bytes fill TX behind the active byte, the 10th write is dropped
    wr(A_CTRL, 32'h0000_0003);
    for (int i = 0; i < 9; i++) wr(A_DATA, 32'h10 + i);
    wr(A_DATA, 32'h99);
    rd(A_STAT, 32'h0000_0817, "ovf_tx_stat");
    wait_idle("ovf");
    rd(A_STAT, 32'h0008_0018, "ovf_both_stat");
    wr(A_STAT, 32'h8);
    rd(A_STAT, 32'h0008_0010, "ovf_rx_clr");
    wr(A_STAT, 32'h10);
    rd(A_STAT, 32'h0008_0000, "ovf_tx_clr");
    for (int i = 0; i < 8; i++) rd(A_DATA, 32'h10 + i, $sformatf("ovf_rx%0d", i));
    rd(A_STAT, 32'h0000_0004, "ovf_drained");

    // Reset mid-byte in mode 3 with both chip selects asserted
    wr(A_CTRL, 32'h0003_0003);
    wr(A_CS, 32'h3);
    check("cs_asserted", spi_cs_n, 2'b00);
    wr(A_DATA, 32'h55);
    wr(A_DATA, 32'h66);
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_cs_n", spi_cs_n, 2'b11);
    check("midrst_sclk", spi_sclk, 1'b0);
    check("midrst_mosi", spi_mosi, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    rd(A_STAT, 32'h0000_0004, "midrst_stat");
    rd(A_CTRL, 32'h0000_0007, "midrst_ctrl");
    rd(A_DATA, 32'h0, "midrst_rx_empty");

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
